fdl_ctrl: RTL
=============

# fdl_ctrl

Thermometer-code controller that drives the T/Tb select inputs of the 8-stage fine delay line. It low-pass filters up/down decisions from the phase detector, steps the fine code by one stage at a time, and hands overflow/underflow to the coarse delay line through a req/ack handshake. It sits between the phase detector and the fine delay line in the DLL loop and asserts a lock indication.

## Interface
- N, 8: number of fine delay stages, which is the width of T/Tb.
- FILT_W, 4: width of the signed filter counter. The threshold TH = 2^(FILT_W-1), which is 8 at the default.
- LOCK_REV, 4: number of consecutive alternating-direction steps needed to assert locked.
- clk_in  in  1  loop clock.
- rst_n  in  1  reset, asynchronous, active-low.
- en  in  1  loop enable.
- pd_up  in  1  phase detector: increase delay.
- pd_dn  in  1  phase detector: decrease delay.
- cdl_ack  in  1  coarse line acknowledge.
- T  out  N  thermometer select to the fine line; T[i] = (i < code).
- Tb  out  N  bitwise complement of T, registered alongside it.
- code  out  $clog2(N+1)  current fine code, range 0..N.
- cdl_inc  out  1  coarse increment request, level, held until ack.
- cdl_dec  out  1  coarse decrement request, level, held until ack.
- locked  out  1  lock indication.

## Operation
- States:
  - IDLE: en low.
  - TRACK: filtering and stepping.
  - WAIT_ACK: coarse request outstanding.
- Reset values:
  - State IDLE, filt 0, code N/2 (4).
  - T 8'h0F, Tb 8'hF0.
  - cdl_inc 0, cdl_dec 0, locked 0, reversal count 0.
- IDLE to TRACK when en=1. TRACK to IDLE when en=0.
- On entering IDLE, filt is cleared. Code, T, Tb and locked hold.
- Filter, in TRACK only:
  - pd_up & ~pd_dn gives filt+1.
  - pd_dn & ~pd_up gives filt-1.
  - Both or neither: hold.
- Up step: when the next filt value would reach +TH, filt becomes 0 and an up step is taken.
  - code<N: code+1.
  - code==N: assert cdl_inc, go to WAIT_ACK; code unchanged.
- Down step: when the next filt value would reach -TH, filt becomes 0 and a down step is taken.
  - code>0: code-1.
  - code==0: assert cdl_dec, go to WAIT_ACK.
- WAIT_ACK:
  - pd inputs are ignored and filt is held at 0.
  - On the first clk_in edge with cdl_ack=1, the request drops and code is set: 0 after inc, N after dec.
  - Then go to TRACK if en=1, else IDLE.
- A request is never withdrawn; en falling during WAIT_ACK still waits for ack.
- cdl_ack while no request is outstanding is ignored.
- cdl_inc and cdl_dec are never high together.
- Lock detector:
  - Each fine step whose direction is opposite to the previous step increments the reversal count, saturating at LOCK_REV. locked=1 when the count equals LOCK_REV.
  - A same-direction step sets the count to 1 and clears locked.
  - Any coarse request clears the count and locked.

## Timing
- T, Tb and code are registered and update on the same clk_in edge as the filter crossing. Latency from the qualifying pd sample to the new T is 1 edge.
- From filt=0 with pd_up held, the code changes on the 8th edge (TH=8). The next change comes 8 edges later.
- A normal fine step toggles exactly one T bit and one Tb bit.
- Wrap (ack) toggles all bits in one edge: N to 0 after inc, 0 to N after dec.
- cdl_inc/cdl_dec rise on the crossing edge and fall on the ack edge. The minimum request width is 1 cycle when ack is already high on the next edge.
- locked updates on the same edge as the step that qualifies or disqualifies it.
- An asynchronous rst_n assertion mid-request drops cdl_inc/cdl_dec immediately and restores all reset values.

## Configuration
- FDL_CTRL_LOCK_EN:
  - Defined: the lock detector is built as described.
  - Undefined: no reversal counter; locked is tied 0 and LOCK_REV is unused. All other behaviour is identical.

## Test plan
- Reset: rst_n low, then high with en=1 and no pd activity. T=8'h0F, Tb=8'hF0, code=4, no requests, locked=0 for 100 cycles.
- Up tracking: pd_up=1 continuously.
  - code goes 5,6,7,8 on edges 8,16,24,32.
  - T reaches 8'hFF.
  - On edge 40, cdl_inc=1 and state is WAIT_ACK.
  - Ack 3 cycles later: cdl_inc drops, code=0, T=8'h00, Tb=8'hFF.
- Down wrap: from code=0 with pd_dn held, cdl_dec asserts after 8 edges. On ack, code=8 and T=8'hFF. Drive en=0 before the ack: the request holds until ack, then state is IDLE.
- Filter hold: pd_up and pd_dn both high for 50 cycles, then 7 up cycles. No code change; filt=+7.
- Lock (macro defined): alternate 8 up / 8 down cycles.
  - locked=1 at the 4th alternating step.
  - Two consecutive up steps clear it.
  - Undefined build: locked stays 0.
- Async reset during WAIT_ACK: rst_n low mid-request. cdl_inc drops without a clock edge; code=4.

Source files
------------

// File: rtl/fdl_ctrl.sv
// fdl_ctrl: thermometer-code controller for the 8-stage fine delay line.
// Filters phase-detector up/down decisions, steps the fine code one stage at
// a time, and hands overflow/underflow to the coarse line via req/ack.
// Optional lock detector is built when FDL_CTRL_LOCK_EN is defined;
// otherwise locked is tied low.
module fdl_ctrl #(
    parameter int N        = 8,
    parameter int FILT_W   = 4,
    parameter int LOCK_REV = 4
) (
    input  logic                     clk_in,
    input  logic                     rst_n,
    input  logic                     en,
    input  logic                     pd_up,
    input  logic                     pd_dn,
    input  logic                     cdl_ack,
    output logic [N-1:0]             T,
    output logic [N-1:0]             Tb,
    output logic [$clog2(N+1)-1:0]   code,
    output logic                     cdl_inc,
    output logic                     cdl_dec,
    output logic                     locked
);

    localparam int                     CW     = $clog2(N+1);
    localparam logic [CW-1:0]          N_C    = CW'(N);
    localparam logic [CW-1:0]          MID_C  = CW'(N / 2);
    localparam int                     TH     = 2 ** (FILT_W - 1);
    localparam logic signed [FILT_W:0] TH_POS = (FILT_W + 1)'(TH);
    localparam logic signed [FILT_W:0] TH_NEG = -TH_POS;
    localparam logic signed [FILT_W:0] ONE    = (FILT_W + 1)'(1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        TRACK    = 2'd1,
        WAIT_ACK = 2'd2
    } state_t;

    state_t                     state;
    logic signed [FILT_W-1:0]   filt;
    logic signed [FILT_W:0]     filt_ext;
    logic signed [FILT_W:0]     filt_sum;
    logic                       pd_inc;
    logic                       pd_dec;
    logic                       track_active;
    logic                       up_cross;
    logic                       dn_cross;
    logic                       fine_up;
    logic                       fine_dn;
    logic                       coarse_req;
    logic                       ack_wrap;
    logic [CW-1:0]              code_nxt;

    // Thermometer encoding: stage i is selected when i < c.
    function automatic logic [N-1:0] therm(input logic [CW-1:0] c);
        logic [N-1:0] r;
        for (int i = 0; i < N; i++) begin
            r[i] = (i < int'(c));
        end
        return r;
    endfunction

    // Filter arithmetic is one bit wider so +TH is representable as a crossing.
    // NOTE: every signal written in always_comb gets a default first, so no
    // path through the block leaves it unassigned and no latch is inferred.
    always_comb begin
        pd_inc       = pd_up & ~pd_dn;
        pd_dec       = pd_dn & ~pd_up;
        filt_ext     = {filt[FILT_W-1], filt};
        filt_sum     = filt_ext;
        if (pd_inc) filt_sum = filt_ext + ONE;
        if (pd_dec) filt_sum = filt_ext - ONE;
        track_active = (state == TRACK) && en;
        up_cross     = track_active && pd_inc && (filt_sum == TH_POS);
        dn_cross     = track_active && pd_dec && (filt_sum == TH_NEG);
        fine_up      = up_cross && (code != N_C);
        fine_dn      = dn_cross && (code != '0);
        coarse_req   = (up_cross && (code == N_C)) || (dn_cross && (code == '0));
        ack_wrap     = (state == WAIT_ACK) && cdl_ack;
        code_nxt     = code;
        if (fine_up) code_nxt = code + CW'(1);
        if (fine_dn) code_nxt = code - CW'(1);
        if (ack_wrap) code_nxt = cdl_inc ? '0 : N_C;
    end

    // Fine code and its thermometer/complement outputs, registered together.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            code <= MID_C;
            T    <= therm(MID_C);
            Tb   <= ~therm(MID_C);
        end else begin
            code <= code_nxt;
            T    <= therm(code_nxt);
            Tb   <= ~therm(code_nxt);
        end
    end

    // Control FSM: filter counter, state and coarse-line request levels.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            filt    <= '0;
            cdl_inc <= 1'b0;
            cdl_dec <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    filt <= '0;
                    if (en) state <= TRACK;
                end
                TRACK: begin
                    if (!en) begin
                        state <= IDLE;
                        filt  <= '0;
                    end else if (up_cross || dn_cross) begin
                        filt <= '0;
                        if (coarse_req) begin
                            cdl_inc <= up_cross;
                            cdl_dec <= dn_cross;
                            state   <= WAIT_ACK;
                        end
                    end else begin
                        filt <= filt_sum[FILT_W-1:0];
                    end
                end
                WAIT_ACK: begin
                    // Request is held until ack even if en drops meanwhile.
                    filt <= '0;
                    if (cdl_ack) begin
                        cdl_inc <= 1'b0;
                        cdl_dec <= 1'b0;
                        state   <= en ? TRACK : IDLE;
                    end
                end
                default: begin
                    state   <= IDLE;
                    filt    <= '0;
                    cdl_inc <= 1'b0;
                    cdl_dec <= 1'b0;
                end
            endcase
        end
    end

`ifdef FDL_CTRL_LOCK_EN
    localparam int            RW     = $clog2(LOCK_REV + 1);
    localparam logic [RW-1:0] LOCK_C = RW'(LOCK_REV);

    logic [RW-1:0] rev_cnt;
    logic          last_up;
    logic          opposite;

    // A count of zero means no fine step has been taken since reset/coarse.
    assign opposite = (rev_cnt != '0) && (last_up != fine_up);

    // Reversal counter: alternating fine steps build toward lock.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            rev_cnt <= '0;
            last_up <= 1'b0;
            locked  <= 1'b0;
        end else if (coarse_req) begin
            rev_cnt <= '0;
            locked  <= 1'b0;
        end else if (fine_up || fine_dn) begin
            last_up <= fine_up;
            if (opposite) begin
                if (rev_cnt != LOCK_C) begin
                    rev_cnt <= rev_cnt + RW'(1);
                    locked  <= ((rev_cnt + RW'(1)) == LOCK_C);
                end
            end else begin
                rev_cnt <= RW'(1);
                locked  <= (LOCK_C == RW'(1));
            end
        end
    end
`else
    logic unused_lock_rev;
    assign unused_lock_rev = (LOCK_REV > 0);
    assign locked          = 1'b0;
`endif

endmodule
